// File: rtl/uart_tx_pkg.sv
// Shared FSM state encoding and 8N1 frame constants for the UART transmitter.
package uart_tx_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] START_ENC = 2'd1;
  localparam logic [1:0] DATA_ENC  = 2'd2;
  localparam logic [1:0] STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    START = START_ENC,
    DATA  = DATA_ENC,
    STOP  = STOP_ENC
  } state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO with wrap-around pointers carrying one extra bit to tell full from empty.
module byte_fifo
  import uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [AW:0]          wptr_nxt;
  logic [AW:0]          rptr_nxt;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  // Next pointer values; flags are registered from these so they track occupancy exactly.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (do_push) wptr_nxt = wptr + (AW+1)'(1);
    if (do_pop)  rptr_nxt = rptr + (AW+1)'(1);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      empty <= (wptr_nxt == rptr_nxt);
      full  <= (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO front end, framing FSM and baud counter.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 sending,
  output logic                 txd
);

  localparam int unsigned BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned BW         = $clog2(BIT_CYCLES);
  localparam int unsigned IW         = $clog2(DATA_BITS);

  state_t               state;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 baud_end;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  assign baud_end = (baud == BW'(BIT_CYCLES - 1));
  assign push     = in_valid && !fifo_full;
  assign in_ready = !fifo_full;

  // Pop when idle with data waiting, or at the end of a stop bit to chain frames.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Framing FSM, baud/bit counters and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= STOP_BIT;
      sending <= 1'b0;
    end else begin
      // txd follows the current state, which places the first falling edge two cycles after accept.
      case (state)
        IDLE:    txd <= STOP_BIT;
        START:   txd <= START_BIT;
        DATA:    txd <= shift[0];
        STOP:    txd <= STOP_BIT;
        default: txd <= STOP_BIT;
      endcase

      // Stays high until the last stop bit has left the txd register.
      sending <= push || !fifo_empty || (state != IDLE);

      case (state)
        IDLE: begin
          baud <= '0;
          if (!fifo_empty) begin
            shift   <= fifo_dout;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shift <= {1'b0, shift[DATA_BITS-1:1]};
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (!fifo_empty) begin
              shift   <= fifo_dout;
              bit_idx <= '0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with 4 clk cycles per bit (40 per frame).
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sending;
  logic       txd;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;

  uart_tx #(
    .CLK_PER_HALF_BIT (2),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sending  (sending),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts handshakes seen on the producer interface.
  always @(posedge clk) begin
    if (in_valid && in_ready && !rst) acc_cnt <= acc_cnt + 1;
  end

  // Checks one 40-cycle frame starting at the negedge of its first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input string name);
    logic [7:0] dec;
    logic [3:0] seen;
    logic       expb;
    logic       send_ok;
    dec = '0;
    send_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < 4; c++) begin
        seen[c] = txd;
        if (sending !== 1'b1) send_ok = 1'b0;
        if (c == 2 && k >= 1 && k <= 8) dec[k-1] = txd;
        @(negedge clk);
      end
      checks++;
      if (seen !== {4{expb}}) begin
        errors++;
        $display("FAIL %s bit%0d: txd samples=%b required=%b", name, k, seen, {4{expb}});
      end
    end
    checks++;
    if (dec !== b) begin
      errors++;
      $display("FAIL %s decode: got=%h required=%h", name, dec, b);
    end
    checks++;
    if (!send_ok) begin
      errors++;
      $display("FAIL %s sending: dropped during frame, required=1", name);
    end
  endtask

  // Checks that the line stays idle and sending stays low for n cycles.
  task automatic check_quiet(input int n, input string name);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (txd !== 1'b1 || sending !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s quiet: txd/sending activity seen, required txd=1 sending=0", name);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (txd !== 1'b1 || sending !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: txd=%b sending=%b in_ready=%b required 1,0,1", name, txd, sending, in_ready);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sending !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: sending=%b txd=%b required 1,1", sending, txd);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL single_latency1: txd=%b required 1", txd);
    end
    @(negedge clk);
    check_frame(8'hA5, "single_a5");
    checks++;
    if (sending !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_end: sending=%b txd=%b required 0,1", sending, txd);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    in_data = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(8'h01, "b2b_01");
    check_frame(8'h02, "b2b_02");
    check_frame(8'h03, "b2b_03");
    checks++;
    if (sending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: sending=%b required 0 after 120 line cycles", sending);
    end
  endtask

  task automatic test_fifo_full();
    int base;
    in_valid = 1'b1;
    in_data = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    base = acc_cnt;
    in_valid = 1'b1;
    in_data = 8'h3C;
    repeat (37) @(negedge clk);
    checks++;
    if (acc_cnt - base != 4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: accepted=%0d in_ready=%b required 4,0", acc_cnt - base, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: in_ready=%b required 0", in_ready);
    end
    repeat (18) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (acc_cnt - base != 5) begin
      errors++;
      $display("FAIL full_total: accepted=%0d required 5", acc_cnt - base);
    end
    pulse_reset();
    check_idle("full_cleanup");
  endtask

  task automatic test_reset_midframe();
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h81;
    @(negedge clk);
    in_data = 8'h42;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL midrst_start: txd=%b required 0", txd);
    end
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst_after");
    check_quiet(100, "midrst_discard");
  endtask

  task automatic test_valid_in_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_idle("rstvalid_after");
    check_quiet(60, "rstvalid_nosend");
  endtask

  task automatic test_zero_ff();
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_frame(8'h00, "pat_00");
    check_frame(8'hFF, "pat_ff");
    checks++;
    if (sending !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL pat_end: sending=%b txd=%b required 0,1", sending, txd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (4) @(negedge clk);
    test_back_to_back();
    repeat (4) @(negedge clk);
    test_fifo_full();
    test_reset_midframe();
    test_valid_in_reset();
    test_zero_ff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 5208, giving half a bit period in clk cycles; one bit period is 2*CLK_PER_HALF_BIT cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of byte entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  8  byte to transmit, sampled on accept.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept; equals not-full.
REQ-008 SHALL have port sending  output  1  high while the FIFO is non-empty or a frame is on the line; core stalls on it.
REQ-009 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-010 SHALL accept a byte on a clk edge where in_valid and in_ready are both high; it SHALL ignore in_data at all other times.
REQ-011 SHALL drive in_ready low when the FIFO holds FIFO_DEPTH entries; a same-cycle pop SHALL NOT make in_ready high in that cycle.
REQ-012 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly 2*CLK_PER_HALF_BIT cycles.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: txd=1; if FIFO non-empty, pop the head into the shift register and go to START on that edge.
REQ-015 START: txd=0 for one bit period, then go to DATA with bit index 0.
REQ-016 DATA: txd=shift[0] for one bit period, then shift right and increment the index; after index 7 go to STOP.
REQ-017 STOP: txd=1 for one bit period; at its end, if the FIFO is non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-018 SHALL time bit periods with a baud counter from 0 to 2*CLK_PER_HALF_BIT-1 that clears on every state entry; the counter width SHALL be $clog2(2*CLK_PER_HALF_BIT).
REQ-019 SHALL delay the first txd falling edge by exactly 2 cycles after the accept edge when the block is IDLE with an empty FIFO.
REQ-020 SHALL drive sending high from the cycle after the first accept until the cycle after the final STOP bit period ends with an empty FIFO.
REQ-021 SHALL permit a push and a pop in the same cycle when the FIFO is neither full nor empty; the occupancy is unchanged.
REQ-022 SHALL use read and write pointers that wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
REQ-023 SHALL register txd with no combinational path from any input to txd.
REQ-024 SHALL treat in_valid held high as a new byte on every accepting edge; the producer is responsible for deasserting it.

Reset
REQ-025 When rst is high at a clk edge, the block SHALL set state=IDLE, txd=1, sending=0, in_ready=1, clear the FIFO pointers and clear the baud and bit counters.
REQ-026 Reset mid-frame SHALL abort the frame; txd SHALL be 1 in the cycle after the reset edge, and queued bytes SHALL be discarded.
REQ-027 in_valid asserted during rst SHALL NOT be accepted.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit localparams IDLE/START/DATA/STOP) and the 8N1 frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
REQ-029 The FIFO SHALL be a sub-module named byte_fifo (parameter DEPTH; push, pop, din, dout, full, empty); the framing FSM and baud counter SHALL stay in uart_tx.

Verification (bench uses CLK_PER_HALF_BIT=2, so 4 cycles/bit and 40 cycles/frame)
REQ-030 Push 0xA5 once with the block idle -> txd falls 2 cycles later, and the line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; sending drops after 40 line cycles.
REQ-031 Push 0x01, 0x02, 0x03 back to back -> three contiguous frames with no idle cycles between STOP and START; total 120 cycles of sending.
REQ-032 Hold in_valid high with the line busy -> exactly 4 bytes are accepted, then in_ready=0 until the first pop, then exactly 1 more byte is accepted.
REQ-033 Assert rst for 1 cycle at line cycle 15 of a 0xFF frame with 2 bytes queued -> txd=1, sending=0, in_ready=1 next cycle, and no further frames are sent.
REQ-034 Assert in_valid during rst with in_data=0x55 -> no frame is sent and sending stays 0.
REQ-035 Push 0x00 then 0xFF -> the line shows start+8 zeros+stop, then start+8 ones+stop; a monitor decoding at mid-bit recovers 0x00 and 0xFF.
